// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: data-cache geometry and controller state encoding.
package dcache_ctrl_pkg;
    localparam int DBLOCK_SIZE      = 16;
    localparam int DBLOCK_SIZE_BITS = DBLOCK_SIZE * 8;
    localparam int DTAG_SIZE        = 3;
    localparam int DSET_INDEX_SIZE  = 1;
    localparam int OFF_W            = $clog2(DBLOCK_SIZE);
    localparam int BADDR_W          = DTAG_SIZE + DSET_INDEX_SIZE;
    localparam int ADDR_W           = BADDR_W + OFF_W;
    localparam int WORD_W           = 32;
    localparam int WIDX_W           = OFF_W - 2;
    typedef enum logic [1:0] {DC_IDLE, DC_WB, DC_REFILL, DC_REPLAY} dc_state_e;
endpackage

// File: rtl/dcache_lane_sel.sv
// dcache_lane_sel: word extract from a block, and byte-lane mask / data shift for a word store.
module dcache_lane_sel import dcache_ctrl_pkg::*; (
    input  logic [WIDX_W-1:0]           widx,
    input  logic [DBLOCK_SIZE_BITS-1:0] block,
    input  logic [WORD_W-1:0]           wdata,
    input  logic [3:0]                  byteen,
    output logic [WORD_W-1:0]           rdata,
    output logic [DBLOCK_SIZE-1:0]      lanes,
    output logic [DBLOCK_SIZE_BITS-1:0] din
);
    assign rdata = block[widx*WORD_W +: WORD_W];
    assign lanes = DBLOCK_SIZE'(byteen) << {widx, 2'b00};
    assign din   = DBLOCK_SIZE_BITS'(wdata) << {widx, 5'b00000};
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back/write-allocate D_SRAM controller with dirty write-back and block refill.
module dcache_ctrl import dcache_ctrl_pkg::*; (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cpu_ren,
    input  logic                        cpu_wen,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic [WORD_W-1:0]           cpu_wdata,
    input  logic [3:0]                  cpu_byteen,
    output logic [WORD_W-1:0]           cpu_rdata,
    output logic                        cpu_stall,
    output logic                        sram_ren,
    output logic                        sram_wen,
    output logic                        sram_memWen,
    output logic [DBLOCK_SIZE-1:0]      sram_bytesAccess,
    output logic [BADDR_W-1:0]          sram_blockAddr,
    output logic [DBLOCK_SIZE_BITS-1:0] sram_dataIn,
    input  logic                        sram_hit,
    input  logic                        sram_dirtyBit,
    input  logic [DTAG_SIZE-1:0]        sram_victimTag,
    input  logic [DBLOCK_SIZE_BITS-1:0] sram_dataOut,
    output logic                        mem_ren,
    output logic                        mem_wen,
    output logic [BADDR_W-1:0]          mem_addr,
    output logic [DBLOCK_SIZE_BITS-1:0] mem_wdata,
    input  logic [DBLOCK_SIZE_BITS-1:0] mem_rdata,
    input  logic                        mem_ready
);
    dc_state_e state, next;
    logic [ADDR_W-1:2] l_addr, addr;
    logic [WORD_W-1:0] l_wdata, wdata, word;
    logic [3:0] l_byteen, byteen;
    logic l_store, idle, req, store, miss, unused_lsb;
    logic [BADDR_W-1:0] v_baddr;
    logic [DBLOCK_SIZE_BITS-1:0] v_data, din;
    logic [DBLOCK_SIZE-1:0] lanes;

    assign unused_lsb = ^cpu_addr[1:0];
    // Live CPU request in IDLE, latched copy everywhere else.
    assign idle   = state == DC_IDLE;
    assign addr   = idle ? cpu_addr[ADDR_W-1:2] : l_addr;
    assign wdata  = idle ? cpu_wdata : l_wdata;
    assign byteen = idle ? cpu_byteen : l_byteen;
    assign store  = idle ? cpu_wen : l_store;
    assign req    = idle ? cpu_ren | cpu_wen : 1'b1;
    assign miss   = rst && idle && req && !sram_hit;
    // Kept apart from the main decode so the tag lookup never feeds back into its own address.
    assign sram_blockAddr = (rst && (idle ? req : state == DC_REPLAY || (state == DC_REFILL && mem_ready)))
                          ? addr[ADDR_W-1:OFF_W] : '0;

    dcache_lane_sel u_lane (
        .widx(addr[OFF_W-1:2]), .block(sram_dataOut), .wdata(wdata), .byteen(byteen),
        .rdata(word), .lanes(lanes), .din(din)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DC_IDLE;
            l_addr   <= '0;
            l_wdata  <= '0;
            l_byteen <= '0;
            l_store  <= 1'b0;
            v_baddr  <= '0;
            v_data   <= '0;
        end else begin
            state <= next;
            if (miss) begin
                l_addr   <= cpu_addr[ADDR_W-1:2];
                l_wdata  <= cpu_wdata;
                l_byteen <= cpu_byteen;
                l_store  <= cpu_wen;
                v_baddr  <= {sram_victimTag, cpu_addr[OFF_W +: DSET_INDEX_SIZE]};
                v_data   <= sram_dataOut;
            end
        end
    end

    always_comb begin
        next             = state;
        cpu_rdata        = '0;
        cpu_stall        = 1'b0;
        sram_ren         = 1'b0;
        sram_wen         = 1'b0;
        sram_memWen      = 1'b0;
        sram_bytesAccess = '0;
        sram_dataIn      = '0;
        mem_ren          = 1'b0;
        mem_wen          = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        if (rst) begin
            case (state)
                DC_IDLE, DC_REPLAY: if (req) begin
                    sram_ren         = 1'b1;
                    cpu_stall        = miss;
                    cpu_rdata        = (miss || store) ? '0 : word;
                    sram_wen         = !miss && store;
                    sram_bytesAccess = (!miss && store) ? lanes : '0;
                    sram_dataIn      = (!miss && store) ? din : '0;
                    next             = miss ? (sram_dirtyBit ? DC_WB : DC_REFILL) : DC_IDLE;
                end
                DC_WB: begin
                    cpu_stall = 1'b1;
                    mem_wen   = 1'b1;
                    mem_addr  = v_baddr;
                    mem_wdata = v_data;
                    next      = mem_ready ? DC_REFILL : DC_WB;
                end
                DC_REFILL: begin
                    cpu_stall   = 1'b1;
                    mem_ren     = 1'b1;
                    mem_addr    = l_addr[ADDR_W-1:OFF_W];
                    sram_memWen = mem_ready;
                    sram_dataIn = mem_ready ? mem_rdata : '0;
                    next        = mem_ready ? DC_REPLAY : DC_REFILL;
                end
            endcase
        end
    end
endmodule
